// File: rtl/encode_pkg.sv
// Shared constants and helpers for the registered N-way request encoder.
package encode_pkg;

    localparam logic [1:0] MODE_ONEHOT = 2'b00;
    localparam logic [1:0] MODE_MSB    = 2'b01;
    localparam logic [1:0] MODE_LSB    = 2'b10;
    localparam logic [1:0] MODE_RR     = 2'b11;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    // True when more than one bit is set; clearing the lowest set bit leaves something behind.
    function automatic logic popcnt_gt1(input logic [63:0] v);
        return (v & (v - 64'd1)) != 64'd0;
    endfunction

endpackage

// File: rtl/ffs_rot.sv
// Combinational find-first-set over N bits, starting at a given index and
// scanning up or down with wrap-around.
module ffs_rot #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    input  logic         dir,
    output logic         hit,
    output logic [W-1:0] idx
);

    int pos;

    // Walk N positions from start; the first set bit met wins.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        pos = 0;
        for (int i = 0; i < N; i++) begin
            if (dir) begin
                pos = int'(start) + i;
                if (pos >= N) pos = pos - N;
            end else begin
                pos = int'(start) - i;
                if (pos < 0) pos = pos + N;
            end
            if (!hit && vec[W'(pos)]) begin
                hit = 1'b1;
                idx = W'(pos);
            end
        end
    end

endmodule

// File: rtl/encode_n_seq.sv
// Registered N-way request encoder: collects request lines into a pending set
// and issues one index per grant on a valid/ready output.
module encode_n_seq
    import encode_pkg::*;
#(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in,
    input  logic [1:0]   mode,
    input  logic         clr,
    output logic [W-1:0] out_code,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         err,
    output logic [N-1:0] pending
);

    logic [N-1:0] pending_q, pending_d;
    logic [W-1:0] out_code_q, out_code_d;
    logic         out_valid_q, out_valid_d;
    logic         err_q, err_d;
    logic [W-1:0] rr_ptr_q, rr_ptr_d;

    logic [N-1:0] cand;
    logic         stage_free;
    logic         multi_hot;
    logic [W-1:0] scan_start;
    logic         scan_dir;
    logic         sel_hit;
    logic [W-1:0] sel_idx;
    logic [N-1:0] grant_mask;

    assign cand       = pending_q | in;
    assign stage_free = !out_valid_q || out_ready;
    assign multi_hot  = popcnt_gt1(64'(cand));
    assign grant_mask = {{(N-1){1'b0}}, 1'b1} << sel_idx;

    // Scan origin and direction per mode; strict mode has at most one bit when it loads.
    always_comb begin
        scan_start = '0;
        scan_dir   = DIR_UP;
        case (mode)
            MODE_MSB: begin
                scan_start = W'(N - 1);
                scan_dir   = DIR_DOWN;
            end
            MODE_RR:  scan_start = rr_ptr_q;
            default:  ;
        endcase
    end

    ffs_rot #(.N(N), .W(W)) u_ffs (
        .vec   (cand),
        .start (scan_start),
        .dir   (scan_dir),
        .hit   (sel_hit),
        .idx   (sel_idx)
    );

    // Next-state for pending set, output stage, round-robin pointer and error pulse.
    always_comb begin
        pending_d   = cand;
        out_code_d  = out_code_q;
        out_valid_d = out_valid_q;
        err_d       = 1'b0;
        rr_ptr_d    = rr_ptr_q;
        if (clr) begin
            pending_d   = '0;
            out_valid_d = 1'b0;
        end else if (stage_free) begin
            if (!sel_hit) begin
                out_valid_d = 1'b0;
            end else if (mode == MODE_ONEHOT && multi_hot) begin
                // Ambiguous strict request: drop everything and flag it.
                out_valid_d = 1'b0;
                pending_d   = '0;
                err_d       = 1'b1;
            end else begin
                out_code_d  = sel_idx;
                out_valid_d = 1'b1;
                pending_d   = cand & ~grant_mask;
                if (mode == MODE_RR) begin
                    rr_ptr_d = (sel_idx == W'(N - 1)) ? '0 : sel_idx + W'(1);
                end
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            out_code_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            pending_q   <= pending_d;
            out_code_q  <= out_code_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_code  = out_code_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_encode_n_seq.sv
// Self-checking bench for encode_n_seq (N=8): expected grant codes are queued
// with the stimulus and popped on each completed handshake.
module tb_encode_n_seq;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] in;
    logic [1:0]   mode;
    logic         clr;
    logic [W-1:0] out_code;
    logic         out_valid;
    logic         out_ready;
    logic         err;
    logic [N-1:0] pending;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    encode_n_seq #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .mode      (mode),
        .clr       (clr),
        .out_code  (out_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted grant must match the next queued code.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_grant", 64'(out_code), 64'hFF);
            end else begin
                chk("grant_code", 64'(out_code), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit drained;
        rst_n = 1'b0; in = '0; mode = 2'b00; clr = 1'b0; out_ready = 1'b1;
        #3;
        chk("rst_valid",   64'(out_valid), 0);
        chk("rst_code",    64'(out_code),  0);
        chk("rst_err",     64'(err),       0);
        chk("rst_pending", 64'(pending),   0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        tick();

        // MSB priority: 5 then 2, then idle.
        mode = 2'b01; in = 8'h24; exp_q.push_back(5); exp_q.push_back(2);
        tick(); in = '0;
        chk("t1_valid1", 64'(out_valid), 1);
        chk("t1_code1",  64'(out_code),  5);
        chk("t1_pend1",  64'(pending),   8'h04);
        chk("t1_err",    64'(err),       0);
        tick();
        chk("t1_code2",  64'(out_code),  2);
        tick();
        chk("t1_idle",   64'(out_valid), 0);
        chk("t1_hold",   64'(out_code),  2);

        // LSB priority: 2 then 5.
        mode = 2'b10; in = 8'h24; exp_q.push_back(2); exp_q.push_back(5);
        tick(); in = '0;
        chk("t2_code1",  64'(out_code), 2);
        chk("t2_pend1",  64'(pending),  8'h20);
        tick();
        chk("t2_code2",  64'(out_code), 5);
        chk("t2_pend2",  64'(pending),  8'h00);
        tick();
        chk("t2_idle",   64'(out_valid), 0);

        // Round robin with all lines held: 0..7,0 then drain 1..7.
        mode = 2'b11; in = 8'hFF;
        for (int i = 0; i < 8; i++) exp_q.push_back(i);
        exp_q.push_back(0);
        for (int i = 1; i < 8; i++) exp_q.push_back(i);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("t3_code", 64'(out_code), 64'(i % 8));
        end
        in = '0;
        drained = 1'b0;
        for (int i = 0; i < 40 && !drained; i++) begin
            tick();
            if (out_valid === 1'b0) drained = 1'b1;
        end
        chk("t3_drained", 64'(drained), 1);
        chk("t3_queue",   64'(exp_q.size()), 0);

        // Strict one-hot: single request grants, multi-hot flags an error.
        mode = 2'b00; in = 8'h10; exp_q.push_back(4);
        tick(); in = '0;
        chk("t4_valid", 64'(out_valid), 1);
        chk("t4_code",  64'(out_code),  4);
        tick();
        in = 8'h03;
        tick(); in = '0;
        chk("t4_err",     64'(err),       1);
        chk("t4_novalid", 64'(out_valid), 0);
        chk("t4_pend",    64'(pending),   0);
        tick();
        chk("t4_err_off", 64'(err),       0);
        chk("t4_idle",    64'(out_valid), 0);

        // Back-pressure: grant 7 held while stalled, 0 follows on ready.
        mode = 2'b01; out_ready = 1'b0; in = 8'h81;
        exp_q.push_back(7); exp_q.push_back(0);
        tick(); in = '0;
        chk("t5_code", 64'(out_code), 7);
        chk("t5_pend", 64'(pending),  8'h01);
        tick(); tick();
        chk("t5_hold_code",  64'(out_code),  7);
        chk("t5_hold_valid", 64'(out_valid), 1);
        chk("t5_hold_pend",  64'(pending),   8'h01);
        out_ready = 1'b1;
        tick();
        chk("t5_code2", 64'(out_code), 0);
        chk("t5_pend2", 64'(pending),  0);
        tick();
        chk("t5_idle",  64'(out_valid), 0);

        // Move rr_ptr to 4, then build valid=1 with pending 0C and reset mid-stream.
        mode = 2'b11; in = 8'h08; exp_q.push_back(3);
        tick(); in = '0;
        chk("t6_rr_code", 64'(out_code), 3);
        tick();
        mode = 2'b01; out_ready = 1'b0; in = 8'h1C;
        tick(); in = '0;
        chk("t6_pre_valid", 64'(out_valid), 1);
        chk("t6_pre_pend",  64'(pending),   8'h0C);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 64'(out_valid), 0);
        chk("t6_async_code",  64'(out_code),  0);
        chk("t6_async_pend",  64'(pending),   0);
        chk("t6_async_err",   64'(err),       0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // rr_ptr back at 0 after reset: bit 1 before bit 5.
        mode = 2'b11; out_ready = 1'b1; in = 8'h22;
        exp_q.push_back(1); exp_q.push_back(5);
        tick(); in = '0;
        chk("t6_rr_first",  64'(out_code), 1);
        tick();
        chk("t6_rr_second", 64'(out_code), 5);
        tick();
        chk("t6_rr_idle",   64'(out_valid), 0);

        // Synchronous clear with pending work; in ignored in the clear cycle.
        mode = 2'b01; out_ready = 1'b0; in = 8'h31;
        tick(); in = '0;
        chk("t6_clr_pre_code", 64'(out_code), 5);
        chk("t6_clr_pre_pend", 64'(pending),  8'h11);
        clr = 1'b1; in = 8'h80;
        tick(); clr = 1'b0; in = '0;
        chk("t6_clr_pend",  64'(pending),   0);
        chk("t6_clr_valid", 64'(out_valid), 0);
        chk("t6_clr_code",  64'(out_code),  5);
        tick();
        chk("t6_clr_after", 64'(out_valid), 0);
        out_ready = 1'b1;
        tick();

        chk("final_queue", 64'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
